mem_wb_writeback: RTL
=====================

// Module: mem_wb_writeback
// PURPOSE
//  MEM/WB pipeline register and GPR write-port driver: captures the MEM-stage
//  result, waits for (possibly late) load data from data RAM, aligns and
//  extends it, and issues exactly one register-file write per instruction.
//  Drives the general-purpose register file write port (WE/WADDR/WDATA).
// PARAMETERS
//  LOAD_TIMEOUT  16  max cycles in LOAD_WAIT before BUS_ERR; 1..255
// PORTS
//  CLK            in   1   clock, all state on posedge
//  RST            in   1   synchronous reset, active-low
//  STALL          in   1   downstream/global hold of WB stage register
//  FLUSH          in   1   invalidate WB stage (wins over STALL)
//  MEM_VALID      in   1   MEM stage holds a valid instruction
//  MEM_WE         in   1   instruction writes a GPR
//  MEM_WADDR      in   5   destination GPR
//  MEM_WDATA      in   32  ALU/non-load result
//  MEM_LOAD       in   1   instruction is a load
//  MEM_LOAD_TYPE  in   3   000 LB, 001 LH, 011 LW, 100 LBU, 101 LHU
//  MEM_BYTE_OFF   in   2   load address [1:0]
//  DRAM_RVALID    in   1   load data valid this cycle
//  DRAM_RDATA     in   32  load word, little-endian
//  GPR_WE         out  1   register-file write enable (one cycle per instr)
//  GPR_WADDR      out  5   register-file write address
//  GPR_WDATA      out  32  register-file write data
//  STALL_REQ      out  1   WB busy waiting for load data; freeze upstream
//  BUS_ERR        out  1   one-cycle pulse: load timed out, no write
//  ADDR_ERR       out  1   one-cycle pulse: misaligned/reserved load, no write
// BEHAVIOUR
//  - Capture: if FLUSH -> state IDLE; else if STALL|STALL_REQ hold; else latch
//    MEM_* and enter ACTIVE (MEM_VALID=1) or IDLE (MEM_VALID=0).
//  - States: IDLE, ACTIVE, LOAD_WAIT, DONE.
//    ACTIVE non-load: GPR_WE=WE&(WADDR!=0), 1 cycle after capture -> DONE.
//    ACTIVE load: align check first (LH off[0]=1, LW off!=0, reserved type ->
//      ADDR_ERR pulse, no write, DONE). Else if DRAM_RVALID write this cycle
//      -> DONE; else -> LOAD_WAIT, wait counter=1.
//    LOAD_WAIT: STALL_REQ=1; DRAM_RVALID -> write extracted data same cycle,
//      -> DONE; counter==LOAD_TIMEOUT w/o RVALID -> BUS_ERR pulse, -> DONE.
//    DONE: no further writes while held; leaves only on next capture.
//  - STALL_REQ is combinational: 1 in ACTIVE-load w/o RVALID and LOAD_WAIT.
//  - Extraction: byte = RDATA[8*off+:8], half = RDATA[16*off[1]+:16];
//    LB/LH sign-extend, LBU/LHU zero-extend, LW whole word.
//  - GPR_WADDR/GPR_WDATA are 0 whenever GPR_WE=0.
//  - WADDR=0: instruction retires, GPR_WE stays 0.
//  - DRAM_RVALID in IDLE/DONE ignored. FLUSH in LOAD_WAIT abandons the load
//    (no write, no BUS_ERR); late RVALID afterwards ignored.
//  - FLUSH and STALL together: FLUSH wins.
//  - Reset (RST=0, also mid LOAD_WAIT): state IDLE, counter 0, all outputs 0.
// CONFIGURATION
//  WB_RETIRE_CNT_EN defined: adds output RETIRE_CNT[31:0], +1 on every
//   ACTIVE/LOAD_WAIT->DONE transition (incl. WADDR=0, excl. BUS_ERR/ADDR_ERR
//   and flushed), wraps 0xFFFFFFFF->0, reset 0.
//  Undefined: port and counter absent; all other behaviour identical.
// TESTING
//  ALU write r5=0x1234_5678 -> GPR_WE=1 next cycle, once, even with STALL held 3 cycles.
//  LB off=3, RDATA=0x80FF_FF7F with RVALID -> r_d=0xFFFF_FF80; LBU -> 0x0000_0080.
//  LW, RVALID 4 cycles late -> STALL_REQ=1 4 cycles, single write, STALL_REQ=0.
//  LW with no RVALID, LOAD_TIMEOUT=16 -> BUS_ERR pulse at cycle 16, GPR_WE never 1.
//  LH off=1 -> ADDR_ERR pulse, no write; write to r0 -> GPR_WE=0.
//  RST=0 during LOAD_WAIT -> next cycle all outputs 0, later RVALID ignored.

Source files
------------

// File: rtl/mem_wb_writeback.sv
// rtl/mem_wb_writeback.sv - MEM/WB stage register and GPR write-port driver
//
// Captures the MEM-stage result, waits for possibly late load data, aligns
// and extends it, and issues at most one register-file write per instruction.
//
// Parameters:
//   LOAD_TIMEOUT   cycles spent in LOAD_WAIT before BUS_ERR (1..255)
// Optional feature:
//   WB_RETIRE_CNT_EN  adds RETIRE_CNT[31:0], a count of retired instructions
// Ports:
//   CLK, RST              clock, synchronous active-low reset
//   STALL, FLUSH          hold / invalidate the WB stage (FLUSH wins)
//   MEM_*                 MEM-stage instruction fields captured into WB
//   DRAM_RVALID/RDATA     load data return from data RAM
//   GPR_WE/WADDR/WDATA    register-file write port (addr/data zero when idle)
//   STALL_REQ             WB is waiting for load data, freeze upstream
//   BUS_ERR, ADDR_ERR     one-cycle error pulses, no write issued

module mem_wb_writeback #(
   parameter int unsigned LOAD_TIMEOUT = 16
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        STALL,
   input  logic        FLUSH,
   input  logic        MEM_VALID,
   input  logic        MEM_WE,
   input  logic [4:0]  MEM_WADDR,
   input  logic [31:0] MEM_WDATA,
   input  logic        MEM_LOAD,
   input  logic [2:0]  MEM_LOAD_TYPE,
   input  logic [1:0]  MEM_BYTE_OFF,
   input  logic        DRAM_RVALID,
   input  logic [31:0] DRAM_RDATA,
   output logic        GPR_WE,
   output logic [4:0]  GPR_WADDR,
   output logic [31:0] GPR_WDATA,
   output logic        STALL_REQ,
   output logic        BUS_ERR,
   output logic        ADDR_ERR
`ifdef WB_RETIRE_CNT_EN
   ,
   output logic [31:0] RETIRE_CNT
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_LOAD_WAIT, S_DONE} state_e;

   localparam logic [7:0] TIMEOUT_C = 8'(LOAD_TIMEOUT);

   state_e      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        we_q, load_q;
   logic [4:0]  waddr_q;
   logic [31:0] wdata_q;
   logic [2:0]  ltype_q;
   logic [1:0]  off_q;

   logic        capture;
   logic        wr_en;
   logic        wr_ok;
   logic        misaligned;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_data;
   logic [31:0] wr_data;
   logic        stall_req;
   logic        bus_err;
   logic        addr_err;

   assign wr_ok = we_q & (waddr_q != 5'd0);

   // Load alignment and extension from the captured type/offset.
   always_comb begin
      ld_byte    = DRAM_RDATA[{off_q, 3'b000} +: 8];
      ld_half    = DRAM_RDATA[{off_q[1], 4'b0000} +: 16];
      ld_data    = 32'd0;
      misaligned = 1'b1;
      case (ltype_q)
         3'b000: begin ld_data = {{24{ld_byte[7]}}, ld_byte};  misaligned = 1'b0;           end
         3'b001: begin ld_data = {{16{ld_half[15]}}, ld_half}; misaligned = off_q[0];       end
         3'b011: begin ld_data = DRAM_RDATA;                   misaligned = (off_q != 2'd0); end
         3'b100: begin ld_data = {24'd0, ld_byte};             misaligned = 1'b0;           end
         3'b101: begin ld_data = {16'd0, ld_half};             misaligned = off_q[0];       end
         default: begin ld_data = 32'd0;                       misaligned = 1'b1;           end
      endcase
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      wr_en     = 1'b0;
      wr_data   = wdata_q;
      stall_req = 1'b0;
      bus_err   = 1'b0;
      addr_err  = 1'b0;
      capture   = 1'b0;

      case (state_q)
         S_ACTIVE: begin
            if (!load_q) begin
               wr_en   = wr_ok;
               state_d = S_DONE;
            end else if (misaligned) begin
               addr_err = 1'b1;
               state_d  = S_DONE;
            end else if (DRAM_RVALID) begin
               wr_en   = wr_ok;
               wr_data = ld_data;
               state_d = S_DONE;
            end else begin
               stall_req = 1'b1;
               state_d   = S_LOAD_WAIT;
               cnt_d     = 8'd1;
            end
         end
         S_LOAD_WAIT: begin
            stall_req = 1'b1;
            if (DRAM_RVALID) begin
               wr_en   = wr_ok;
               wr_data = ld_data;
               state_d = S_DONE;
               cnt_d   = 8'd0;
            end else if (cnt_q == TIMEOUT_C) begin
               bus_err = 1'b1;
               state_d = S_DONE;
               cnt_d   = 8'd0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: ;
      endcase

      // Stage-register update overrides the per-state progression: a flush
      // drops whatever is in WB; a free-running stage takes the next instr.
      if (FLUSH) begin
         state_d = S_IDLE;
         cnt_d   = 8'd0;
      end else if (!(STALL || stall_req)) begin
         capture = 1'b1;
         state_d = MEM_VALID ? S_ACTIVE : S_IDLE;
         cnt_d   = 8'd0;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q <= S_IDLE;
         cnt_q   <= 8'd0;
         we_q    <= 1'b0;
         load_q  <= 1'b0;
         waddr_q <= 5'd0;
         wdata_q <= 32'd0;
         ltype_q <= 3'd0;
         off_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (capture) begin
            we_q    <= MEM_WE;
            load_q  <= MEM_LOAD;
            waddr_q <= MEM_WADDR;
            wdata_q <= MEM_WDATA;
            ltype_q <= MEM_LOAD_TYPE;
            off_q   <= MEM_BYTE_OFF;
         end
      end
   end

   assign GPR_WE    = wr_en;
   assign GPR_WADDR = wr_en ? waddr_q : 5'd0;
   assign GPR_WDATA = wr_en ? wr_data : 32'd0;
   assign STALL_REQ = stall_req;
   assign BUS_ERR   = bus_err;
   assign ADDR_ERR  = addr_err;

`ifdef WB_RETIRE_CNT_EN
   logic        retire;
   logic [31:0] retire_cnt_q;

   // Retirement covers r0/no-write instructions but not errors or flushes.
   assign retire = !FLUSH &&
                   (((state_q == S_ACTIVE) && (!load_q || (!misaligned && DRAM_RVALID))) ||
                    ((state_q == S_LOAD_WAIT) && DRAM_RVALID));

   always_ff @(posedge CLK) begin
      if (!RST) begin
         retire_cnt_q <= 32'd0;
      end else if (retire) begin
         retire_cnt_q <= retire_cnt_q + 32'd1;
      end
   end

   assign RETIRE_CNT = retire_cnt_q;
`endif

endmodule
